key_pulse_gen: RTL and testbench
================================

// Module: key_pulse_gen
// PURPOSE
//  Multi-channel debounced key-to-pulse converter; generalises the single-key falling-edge pulser.
//  Per channel: synchroniser, debounce filter, selectable edge detect, optional auto-repeat.
//  Sits between board push-buttons and control logic (e.g. UART transmit trigger).
//  All outputs are registered one-cycle strobes or levels in the clk domain.
// PARAMETERS
//  N_KEYS          4        number of independent key channels
//  SYNC_STAGES     2        synchroniser flops per key (>=2)
//  DEBOUNCE_CYCLES 1000000  consecutive stable clocks required to accept a change (>=1)
//  ACTIVE_LOW      1        1: pin low = pressed; 0: pin high = pressed
//  EDGE_MODE       0        0 press edge, 1 release edge, 2 both edges -> pulse
//  REPEAT_DELAY    0        clocks held before first repeat strobe; 0 disables repeat
//  REPEAT_RATE     5000000  clocks between subsequent repeat strobes (>=1)
// PORTS
//  clk        in   1       system clock
//  rst        in   1       asynchronous reset, active high
//  key        in   N_KEYS  raw asynchronous key pins
//  key_level  out  N_KEYS  debounced pressed state, active high
//  pulse      out  N_KEYS  one-cycle strobe on edge selected by EDGE_MODE
//  rpt_pulse  out  N_KEYS  one-cycle auto-repeat strobe while held
//  any_pulse  out  1       registered OR of pulse|rpt_pulse over all channels, 1 cycle late
// BEHAVIOUR
//  Reset (async, rst=1): sync flops = released pin level (1 if ACTIVE_LOW); stable=released;
//   counters 0; key_level, pulse, rpt_pulse, any_pulse = 0.
//  Sync: pin shifted through SYNC_STAGES flops; polarity normalised to pressed=1 after last stage.
//  Debounce: cnt increments each clock synced!=stable; cleared when synced==stable.
//   When cnt would reach DEBOUNCE_CYCLES: stable<=synced, cnt<=0. Width $clog2(DEBOUNCE_CYCLES+1).
//  Glitch shorter than DEBOUNCE_CYCLES clocks (post-sync): no state change, no strobe.
//  key_level = stable. pulse registered from stable transition (press 0->1, release 1->0).
//  Latency: pin change captured at edge 0 -> stable flips at edge SYNC_STAGES+DEBOUNCE_CYCLES-1,
//   pulse high exactly one cycle, from edge SYNC_STAGES+DEBOUNCE_CYCLES.
//  EDGE_MODE 2: press and release each give one strobe; other EDGE_MODE values illegal (elab error).
//  Repeat (REPEAT_DELAY>0): rcnt cleared on press transition; increments while stable=1.
//   First rpt_pulse when rcnt reaches REPEAT_DELAY, then every REPEAT_RATE clocks; rcnt wraps
//   internally, never saturates visibly. Release: rcnt=0, no further rpt_pulse, same cycle.
//   rpt_pulse never coincides with the press pulse. REPEAT_DELAY=0: rpt_pulse tied 0.
//  Channels fully independent; simultaneous events on several keys each strobe in same cycle.
//  any_pulse: registered, one cycle after the corresponding pulse/rpt_pulse.
//  Reset mid-debounce/mid-repeat: all progress discarded; key held across reset deassert
//   re-debounces and yields a fresh press pulse after SYNC_STAGES+DEBOUNCE_CYCLES clocks.
// STRUCTURE
//  key_pkg: EDGE_PRESS=0, EDGE_RELEASE=1, EDGE_BOTH=2 constants; clog2-based width helper.
//  Sub-module key_channel (sync, debounce, edge, repeat for one key); top generates N_KEYS
//   instances plus any_pulse OR-reduce register. No FSM beyond per-channel stable/rcnt state.
// TESTING (bench params: N_KEYS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1,
//  EDGE_MODE=0, REPEAT_DELAY=10, REPEAT_RATE=3)
//  1 Reset: rst=1 with key=2'b00 -> all outputs 0; after release, key0 low held -> pulse[0]
//    exactly 1 cycle at edge 6 after first sampled low, key_level[0]=1 from edge 5.
//  2 Glitch: key[0] low 3 clocks then high -> no pulse, key_level stays 0.
//  3 Bounce: low 2, high 1, low held -> single pulse 6 edges after final low edge.
//  4 Repeat: key[1] held 30 clocks -> rpt_pulse[1] at 10,13,16,19,22,25,28 clocks after press
//    pulse; release -> none after stable falls; no release pulse (EDGE_MODE=0).
//  5 EDGE_MODE=2 rerun: press+release of key0 -> exactly 2 strobes; both keys pressed same
//    clock -> pulse=2'b11 same cycle, any_pulse 1 cycle later.
//  6 Reset mid-repeat: assert rst at clock 12 of hold -> outputs 0 immediately; key still held
//    after deassert -> new press pulse 6 edges later, repeat restarts at +10.

Source files
------------

// File: rtl/key_pulse_gen_pkg.sv
// Shared constants and helpers for the key_pulse_gen key-to-pulse converter.
package key_pkg;

  // Edge selection codes for the EDGE_MODE parameter.
  localparam int EDGE_PRESS   = 0;
  localparam int EDGE_RELEASE = 1;
  localparam int EDGE_BOTH    = 2;

  // Bits needed for a counter that must hold values 0..max_val (never narrower than 1).
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_pulse_gen_if.sv
// Key pins in, debounced levels and strobes out; one bit per key channel.
interface key_pulse_gen_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key;        // raw asynchronous pins
  logic [N_KEYS-1:0] key_level;  // debounced pressed state, active high
  logic [N_KEYS-1:0] pulse;      // one-cycle edge strobe
  logic [N_KEYS-1:0] rpt_pulse;  // one-cycle auto-repeat strobe
  logic              any_pulse;  // registered OR of all strobes

  // Board / control side drives the pins and consumes the strobes.
  modport master (
    output key,
    input  key_level, pulse, rpt_pulse, any_pulse
  );

  // The converter itself.
  modport slave (
    input  key,
    output key_level, pulse, rpt_pulse, any_pulse
  );
endinterface

// File: rtl/key_pulse_gen_channel.sv
// One key channel: synchroniser, debounce filter, edge strobe and auto-repeat.
module key_channel
  import key_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int EDGE_MODE       = EDGE_PRESS,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_level,
  output logic pulse,
  output logic rpt_pulse
);

  localparam logic RELEASED_PIN = (ACTIVE_LOW != 0);
  localparam int   DW           = cnt_width(DEBOUNCE_CYCLES);
  localparam int   RMAX         = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int   RW           = cnt_width(RMAX);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pressed_sync;
  logic                   stable;
  logic                   stable_nxt;
  logic                   stable_d;
  logic [DW-1:0]          cnt;
  logic [DW-1:0]          cnt_nxt;
  logic                   pulse_nxt;
  logic                   pulse_q;

  // Synchroniser shift register; resets to the released pin level so no false press appears.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RELEASED_PIN}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key};
    end
  end

  // Normalise polarity after the last stage so the rest of the channel sees pressed = 1.
  assign pressed_sync = (ACTIVE_LOW != 0) ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

  // Debounce: count consecutive disagreeing clocks, accept the new level on the last one.
  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = '0;
    if (pressed_sync != stable) begin
      if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        stable_nxt = pressed_sync;
      end else begin
        cnt_nxt = cnt + DW'(1);
      end
    end
  end

  // Edge selection on the registered stable level and its one-cycle-old copy.
  always_comb begin
    pulse_nxt = 1'b0;
    if (EDGE_MODE == EDGE_PRESS) begin
      pulse_nxt = stable & ~stable_d;
    end else if (EDGE_MODE == EDGE_RELEASE) begin
      pulse_nxt = ~stable & stable_d;
    end else begin
      pulse_nxt = stable ^ stable_d;
    end
  end

  // Debounce state, delayed copy for edge detection, and the registered edge strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
      pulse_q  <= 1'b0;
    end else begin
      stable   <= stable_nxt;
      stable_d <= stable;
      cnt      <= cnt_nxt;
      pulse_q  <= pulse_nxt;
    end
  end

  assign key_level = stable;
  assign pulse     = pulse_q;

  if (REPEAT_DELAY > 0) begin : g_repeat
    logic [RW-1:0] rcnt;
    logic          rphase;   // 0: waiting for first repeat, 1: steady repeat rate
    logic [RW-1:0] target;
    logic          held;
    logic          hit;
    logic          rpt_q;

    // The key counts as held only while it is pressed now and stays pressed next cycle,
    // so a release cancels any strobe due on the same edge.
    assign held   = stable & stable_nxt;
    assign target = rphase ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
    assign hit    = held && (rcnt == target);

    // Repeat counter: restarts on every press, reloads to 1 after each strobe, cleared on release.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rcnt   <= '0;
        rphase <= 1'b0;
        rpt_q  <= 1'b0;
      end else begin
        rpt_q <= hit;
        if (!held) begin
          rcnt   <= '0;
          rphase <= 1'b0;
        end else if (hit) begin
          rcnt   <= RW'(1);
          rphase <= 1'b1;
        end else begin
          rcnt <= rcnt + RW'(1);
        end
      end
    end

    assign rpt_pulse = rpt_q;
  end else begin : g_no_repeat
    assign rpt_pulse = 1'b0;
  end

endmodule

// File: rtl/key_pulse_gen.sv
// Multi-channel debounced key-to-pulse converter with a combined any_pulse strobe.
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int EDGE_MODE       = EDGE_PRESS,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_RATE     = 5000000
) (
  input logic             clk,
  input logic             rst,
  key_pulse_gen_if.slave  kp
);

  if (EDGE_MODE != EDGE_PRESS && EDGE_MODE != EDGE_RELEASE && EDGE_MODE != EDGE_BOTH) begin : g_bad_edge_mode
    $error("key_pulse_gen: EDGE_MODE must be 0, 1 or 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("key_pulse_gen: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("key_pulse_gen: DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_RATE < 1) begin : g_bad_rate
    $error("key_pulse_gen: REPEAT_RATE must be at least 1");
  end

  logic [N_KEYS-1:0] level_w;
  logic [N_KEYS-1:0] pulse_w;
  logic [N_KEYS-1:0] rpt_w;
  logic              any_q;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .EDGE_MODE      (EDGE_MODE),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_channel (
      .clk      (clk),
      .rst      (rst),
      .key      (kp.key[i]),
      .key_level(level_w[i]),
      .pulse    (pulse_w[i]),
      .rpt_pulse(rpt_w[i])
    );
  end

  // Combined strobe, registered so it trails the per-channel strobes by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |(pulse_w | rpt_w);
    end
  end

  assign kp.key_level = level_w;
  assign kp.pulse     = pulse_w;
  assign kp.rpt_pulse = rpt_w;
  assign kp.any_pulse = any_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen: press-edge instance (A) and both-edge instance (B).
module tb_key_pulse_gen;
  import key_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LAT  = SYNC + DEB;      // edge of the press strobe after first sampled pin change
  localparam int RD   = 10;
  localparam int RR   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  key_pulse_gen_if #(.N_KEYS(2)) if_a ();
  key_pulse_gen_if #(.N_KEYS(2)) if_b ();

  key_pulse_gen #(
    .N_KEYS(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1),
    .EDGE_MODE(EDGE_PRESS), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_a (
    .clk(clk), .rst(rst), .kp(if_a.slave)
  );

  key_pulse_gen #(
    .N_KEYS(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1),
    .EDGE_MODE(EDGE_BOTH), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_b (
    .clk(clk), .rst(rst), .kp(if_b.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Per-edge snapshot: {any_pulse, rpt_pulse[1:0], pulse[1:0], key_level[1:0]}
  logic [6:0] vec_a [0:63];
  logic [6:0] vec_b [0:63];

  function automatic logic [6:0] now_a();
    return {if_a.any_pulse, if_a.rpt_pulse, if_a.pulse, if_a.key_level};
  endfunction

  function automatic logic [6:0] now_b();
    return {if_b.any_pulse, if_b.rpt_pulse, if_b.pulse, if_b.key_level};
  endfunction

  // Expected press-edge instance behaviour for one key pressed at edge 0 and released
  // (first high sample) at edge rel.
  function automatic logic [6:0] exp_hold(input int k, input int rel, input int ch);
    logic [1:0] m;
    logic lv, pl, rp, ap;
    m  = (ch == 1) ? 2'b10 : 2'b01;
    lv = (k >= LAT - 1) && (k < rel + LAT - 1);
    pl = (k == LAT);
    rp = (k >= LAT + RD) && (k <= rel + LAT - 2) && (((k - LAT - RD) % RR) == 0);
    ap = (k == LAT + 1) ||
         ((k >= LAT + RD + 1) && (k <= rel + LAT - 1) && (((k - LAT - RD - 1) % RR) == 0));
    return {ap, rp ? m : 2'b00, pl ? m : 2'b00, lv ? m : 2'b00};
  endfunction

  // Advance n clock edges from a negedge, capturing both instances after each edge.
  task automatic observe(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      vec_a[base + k] = now_a();
      vec_b[base + k] = now_b();
    end
  endtask

  task automatic test_reset();
    logic [6:0] got;
    rst = 1'b1;
    if_a.key = 2'b00;
    if_b.key = 2'b00;
    @(negedge clk);
    @(negedge clk);
    got = now_a();
    n_cmp++;
    if (got !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_outputs_a got=%b exp=%b", got, 7'd0);
    end
    got = now_b();
    n_cmp++;
    if (got !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_outputs_b got=%b exp=%b", got, 7'd0);
    end
    if_a.key = 2'b10;
    if_b.key = 2'b11;
    rst = 1'b0;
    observe(10, 0);
    if_a.key = 2'b11;
    observe(12, 10);
    for (int k = 0; k < 22; k++) begin
      n_cmp++;
      if (vec_a[k] !== exp_hold(k, 10, 0)) begin
        n_bad++;
        $display("FAIL reset_first_press k=%0d got=%b exp=%b", k, vec_a[k], exp_hold(k, 10, 0));
      end
    end
  endtask

  task automatic test_glitch();
    if_a.key = 2'b10;
    observe(3, 0);
    if_a.key = 2'b11;
    observe(12, 3);
    for (int k = 0; k < 15; k++) begin
      n_cmp++;
      if (vec_a[k] !== 7'd0) begin
        n_bad++;
        $display("FAIL glitch k=%0d got=%b exp=%b", k, vec_a[k], 7'd0);
      end
    end
  endtask

  task automatic test_bounce();
    if_a.key = 2'b10;
    observe(2, 0);
    if_a.key = 2'b11;
    observe(1, 2);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (vec_a[k] !== 7'd0) begin
        n_bad++;
        $display("FAIL bounce_prefix k=%0d got=%b exp=%b", k, vec_a[k], 7'd0);
      end
    end
    if_a.key = 2'b10;
    observe(10, 0);
    if_a.key = 2'b11;
    observe(12, 10);
    for (int k = 0; k < 22; k++) begin
      n_cmp++;
      if (vec_a[k] !== exp_hold(k, 10, 0)) begin
        n_bad++;
        $display("FAIL bounce_settle k=%0d got=%b exp=%b", k, vec_a[k], exp_hold(k, 10, 0));
      end
    end
  endtask

  task automatic test_repeat();
    if_a.key = 2'b01;
    observe(30, 0);
    if_a.key = 2'b11;
    observe(15, 30);
    for (int k = 0; k < 45; k++) begin
      n_cmp++;
      if (vec_a[k] !== exp_hold(k, 30, 1)) begin
        n_bad++;
        $display("FAIL repeat k=%0d got=%b exp=%b", k, vec_a[k], exp_hold(k, 30, 1));
      end
    end
  endtask

  task automatic test_edge_both();
    logic [6:0] e;
    logic [1:0] m;
    int strobes;
    // Single key press and release: one strobe on each edge, no repeat for a 10-clock hold.
    if_b.key = 2'b10;
    observe(10, 0);
    if_b.key = 2'b11;
    observe(12, 10);
    strobes = 0;
    m = 2'b01;
    for (int k = 0; k < 22; k++) begin
      e = {(k == LAT + 1) || (k == LAT + 11), 2'b00,
           ((k == LAT) || (k == LAT + 10)) ? m : 2'b00,
           ((k >= LAT - 1) && (k < LAT + 9)) ? m : 2'b00};
      if (vec_b[k][2]) strobes++;
      n_cmp++;
      if (vec_b[k] !== e) begin
        n_bad++;
        $display("FAIL both_single k=%0d got=%b exp=%b", k, vec_b[k], e);
      end
    end
    n_cmp++;
    if (strobes !== 2) begin
      n_bad++;
      $display("FAIL both_strobe_count got=%0d exp=%0d", strobes, 2);
    end
    // Both keys in the same clock: both channels strobe together, any_pulse one cycle later.
    if_b.key = 2'b00;
    observe(10, 0);
    if_b.key = 2'b11;
    observe(12, 10);
    m = 2'b11;
    for (int k = 0; k < 22; k++) begin
      e = {(k == LAT + 1) || (k == LAT + 11), 2'b00,
           ((k == LAT) || (k == LAT + 10)) ? m : 2'b00,
           ((k >= LAT - 1) && (k < LAT + 9)) ? m : 2'b00};
      n_cmp++;
      if (vec_b[k] !== e) begin
        n_bad++;
        $display("FAIL both_simultaneous k=%0d got=%b exp=%b", k, vec_b[k], e);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic [6:0] got;
    if_a.key = 2'b01;
    observe(12, 0);
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (vec_a[k] !== exp_hold(k, 40, 1)) begin
        n_bad++;
        $display("FAIL mid_repeat_pre k=%0d got=%b exp=%b", k, vec_a[k], exp_hold(k, 40, 1));
      end
    end
    rst = 1'b1;
    #1;
    got = now_a();
    n_cmp++;
    if (got !== 7'd0) begin
      n_bad++;
      $display("FAIL mid_repeat_async_clear got=%b exp=%b", got, 7'd0);
    end
    @(negedge clk);
    got = now_a();
    n_cmp++;
    if (got !== 7'd0) begin
      n_bad++;
      $display("FAIL mid_repeat_in_reset got=%b exp=%b", got, 7'd0);
    end
    rst = 1'b0;
    observe(20, 0);
    if_a.key = 2'b11;
    observe(12, 20);
    for (int k = 0; k < 32; k++) begin
      n_cmp++;
      if (vec_a[k] !== exp_hold(k, 20, 1)) begin
        n_bad++;
        $display("FAIL mid_repeat_restart k=%0d got=%b exp=%b", k, vec_a[k], exp_hold(k, 20, 1));
      end
    end
  endtask

  initial begin
    if_a.key = 2'b11;
    if_b.key = 2'b11;
    test_reset();
    test_glitch();
    test_bounce();
    test_repeat();
    test_edge_both();
    test_reset_mid_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
